bram_mem_responder: RTL and testbench
=====================================

// Module: bram_mem_responder
// PURPOSE
//  Block-RAM-backed responder for the memCtrl client handshake (i_cs/i_write/o_busy/o_dataReady).
//  Stands in for the PSRAM path, so memory-test and CPU bring-up state machines run without external RAM.
//  It also acts as a reference target: an initiator that passes against it is handshake-correct before PSRAM timing is involved.
//  Sits beside memCtrl in gm64 and is selected in place of it; clocked from clkSys.
// PARAMETERS
//  ADDR_WIDTH  12     implemented address bits; depth = 2**ADDR_WIDTH bytes
//  LATENCY     4      cycles o_busy stays high per access; legal range 1..15
//  INIT_VALUE  8'h00  value written to every location by the post-reset clear sweep
// PORTS
//  i_clkSys       in   1   system clock; all logic on its rising edge
//  i_reset        in   1   synchronous reset, active-high
//  i_cs           in   1   chip select, active-low; must return high between requests
//  i_write        in   1   1 = write, 0 = read; sampled at accept
//  i_address      in   24  byte address; sampled at accept
//  i_dataToWrite  in   8   write data; sampled at accept
//  o_dataRead     out  8   read data; valid while o_dataReady=1
//  o_busy         out  1   1 = clear sweep or access in progress; no accept
//  o_dataReady    out  1   1 = last completed read has valid data
//  o_error        out  1   1 = last accepted address was >= 2**ADDR_WIDTH
// BEHAVIOUR
//  Reset (i_reset=1 at an edge): state=CLEAR, sweep ptr=0, armed=0.
//  Output reset values: o_busy=1, o_dataReady=0, o_dataRead=8'h00, o_error=0.
//  Reset mid-access aborts the access; a pending write is not committed.
//  Reset mid-sweep restarts the sweep at address 0.
//  armed: set on any cycle i_cs=1; cleared on accept.
//    Holding i_cs low therefore yields exactly one request.
//    A request started with i_cs low before armed is set is ignored.
//  accept = state==IDLE && !i_cs && armed.
//  States:
//   CLEAR: mem[ptr]<=INIT_VALUE; ptr++. At ptr==2**ADDR_WIDTH-1 the last write is done,
//     ptr wraps to 0, then ->IDLE with o_busy<=0. i_cs is ignored, but armed still tracks i_cs.
//     Sweep length: 2**ADDR_WIDTH cycles after reset release.
//   IDLE: o_busy=0. On accept:
//     latch i_write, i_address, i_dataToWrite; cnt<=LATENCY-1; o_busy<=1;
//     o_dataReady<=0; o_error<=0; ->WAIT.
//   WAIT: cnt-- each cycle. At an edge with cnt==0, complete the access:
//     in-range write: mem[addr[ADDR_WIDTH-1:0]]<=data.
//     in-range read: o_dataRead<=mem[...]; o_dataReady<=1.
//     out of range (addr[23:ADDR_WIDTH]!=0): write dropped; read returns 8'hFF with o_dataReady<=1; o_error<=1.
//     Then o_busy<=0 and ->IDLE.
//  Latency: accept at edge N gives o_busy=1 for edges N+1..N+LATENCY; completion shows at edge N+LATENCY.
//    Earliest next accept is edge N+LATENCY+1, and only if i_cs went high in between.
//  o_dataReady and o_dataRead hold until the next accept.
//    A write completion leaves o_dataReady=0.
//  Inputs are not looked at while o_busy=1, apart from armed tracking.
//  Read-after-write to the same address returns the new data; there is no write buffering.
//  Memory must infer a single-port BRAM: one access per cycle, registered read.
// TESTING
//  1. Reset 1 cycle, ADDR_WIDTH=4 -> o_busy=1 for exactly 16 cycles after release, then 0.
//     Every location then reads 8'h00.
//  2. Write 8'hAA to addr 1 (i_cs low 1 cycle), then read addr 1 -> o_busy high 4 cycles each.
//     o_dataReady=1, o_dataRead=8'hAA; o_error=0.
//  3. i_cs held low 20 cycles -> exactly one access; a second needs i_cs=1 then 0.
//  4. Read addr 24'h001000 (ADDR_WIDTH=12) -> o_dataRead=8'hFF, o_error=1, o_dataReady=1.
//     A prior write to 24'h001000 left mem[0] unchanged.
//  5. i_reset at 2nd WAIT cycle of write 8'h55 to addr 7 -> sweep restarts; addr 7 reads INIT_VALUE.
//  6. gm64-style loop: write/read 8'hAA over addrs 1..4095, LATENCY=1 and 15 -> all reads match.
//     o_busy never drops mid-access.

Source files
------------

// File: rtl/bram_mem_responder.sv
// ============================================================================
// Module  : bram_mem_responder
// Purpose : Block-RAM stand-in for the PSRAM path behind the memCtrl handshake.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module bram_mem_responder #(
    parameter int          ADDR_WIDTH = 12,
    parameter int          LATENCY    = 4,
    parameter logic [7:0]  INIT_VALUE = 8'h00
) (
    input  logic        i_clkSys,
    input  logic        i_reset,
    input  logic        i_cs,
    input  logic        i_write,
    input  logic [23:0] i_address,
    input  logic [7:0]  i_dataToWrite,
    output logic [7:0]  o_dataRead,
    output logic        o_busy,
    output logic        o_dataReady,
    output logic        o_error
);

    localparam int                    c_DEPTH    = 2 ** ADDR_WIDTH;
    localparam logic [3:0]            c_CNT_INIT = 4'(LATENCY - 1);
    localparam logic [ADDR_WIDTH-1:0] c_PTR_LAST = {ADDR_WIDTH{1'b1}};

    localparam logic [1:0] c_ST_CLEAR = 2'd0;
    localparam logic [1:0] c_ST_IDLE  = 2'd1;
    localparam logic [1:0] c_ST_WAIT  = 2'd2;

    logic [1:0]            r_state;
    logic [ADDR_WIDTH-1:0] r_ptr;
    logic                  r_armed;
    logic [3:0]            r_cnt;
    logic                  r_write;
    logic [23:0]           r_addr;
    logic [7:0]            r_wdata;

    logic [7:0]            r_mem [c_DEPTH];

    logic                  w_accept;
    logic                  w_done;
    logic                  w_oor;
    logic                  w_mem_we;
    logic                  w_mem_re;
    logic                  w_oor_rd;
    logic [ADDR_WIDTH-1:0] w_mem_addr;
    logic [7:0]            w_mem_wdata;

    generate
        if (ADDR_WIDTH < 24) begin : g_range_check
            assign w_oor = |r_addr[23:ADDR_WIDTH];
        end else begin : g_full_range
            assign w_oor = 1'b0;
        end
    endgenerate

    // The single memory port is shared by the clear sweep and access completion;
    // the two never coincide because they belong to different states.
    always_comb begin
        w_accept    = (r_state == c_ST_IDLE) && !i_cs && r_armed;
        w_done      = (r_state == c_ST_WAIT) && (r_cnt == 4'd0);
        w_mem_we    = 1'b0;
        w_mem_re    = 1'b0;
        w_oor_rd    = 1'b0;
        w_mem_addr  = r_addr[ADDR_WIDTH-1:0];
        w_mem_wdata = r_wdata;
        if (r_state == c_ST_CLEAR) begin
            w_mem_addr  = r_ptr;
            w_mem_wdata = INIT_VALUE;
            w_mem_we    = !i_reset;
        end else if (w_done && !i_reset) begin
            w_mem_we = r_write && !w_oor;
            w_mem_re = !r_write && !w_oor;
            w_oor_rd = !r_write && w_oor;
        end
    end

    always_ff @(posedge i_clkSys) begin
        if (w_mem_we) begin
            r_mem[w_mem_addr] <= w_mem_wdata;
        end
    end

    always_ff @(posedge i_clkSys) begin
        if (i_reset) begin
            o_dataRead <= 8'h00;
        end else if (w_mem_re) begin
            o_dataRead <= r_mem[w_mem_addr];
        end else if (w_oor_rd) begin
            o_dataRead <= 8'hFF;
        end
    end

    always_ff @(posedge i_clkSys) begin
        if (i_reset) begin
            r_state     <= c_ST_CLEAR;
            r_ptr       <= '0;
            r_armed     <= 1'b0;
            r_cnt       <= 4'd0;
            r_write     <= 1'b0;
            r_addr      <= 24'd0;
            r_wdata     <= 8'h00;
            o_busy      <= 1'b1;
            o_dataReady <= 1'b0;
            o_error     <= 1'b0;
        end else begin
            // Re-arming needs i_cs high for a cycle, so a held-low i_cs is one request.
            if (i_cs) begin
                r_armed <= 1'b1;
            end else if (w_accept) begin
                r_armed <= 1'b0;
            end

            case (r_state)
                c_ST_CLEAR: begin
                    r_ptr <= r_ptr + 1'b1;
                    if (r_ptr == c_PTR_LAST) begin
                        r_state <= c_ST_IDLE;
                        o_busy  <= 1'b0;
                    end
                end
                c_ST_IDLE: begin
                    if (w_accept) begin
                        r_write     <= i_write;
                        r_addr      <= i_address;
                        r_wdata     <= i_dataToWrite;
                        r_cnt       <= c_CNT_INIT;
                        o_busy      <= 1'b1;
                        o_dataReady <= 1'b0;
                        o_error     <= 1'b0;
                        r_state     <= c_ST_WAIT;
                    end
                end
                c_ST_WAIT: begin
                    if (r_cnt == 4'd0) begin
                        o_dataReady <= !r_write;
                        o_error     <= w_oor;
                        o_busy      <= 1'b0;
                        r_state     <= c_ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: begin
                    r_state <= c_ST_CLEAR;
                    r_ptr   <= '0;
                    o_busy  <= 1'b1;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_bram_mem_responder.sv
// ============================================================================
// Module  : tb_bram_mem_responder
// Purpose : Directed self-checking bench for bram_mem_responder.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bram_mem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        cs   [4];
    logic        wr   [4];
    logic [23:0] addr [4];
    logic [7:0]  wd   [4];
    logic [7:0]  rd   [4];
    logic        busy [4];
    logic        rdy  [4];
    logic        err  [4];

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    // 0: main (AW=12, L=4)  1: small (AW=4, L=4)  2: L=1  3: L=15
    bram_mem_responder #(.ADDR_WIDTH(12), .LATENCY(4), .INIT_VALUE(8'h00)) u_main (
        .i_clkSys(clk), .i_reset(rst), .i_cs(cs[0]), .i_write(wr[0]),
        .i_address(addr[0]), .i_dataToWrite(wd[0]), .o_dataRead(rd[0]),
        .o_busy(busy[0]), .o_dataReady(rdy[0]), .o_error(err[0]));

    bram_mem_responder #(.ADDR_WIDTH(4), .LATENCY(4), .INIT_VALUE(8'h00)) u_small (
        .i_clkSys(clk), .i_reset(rst), .i_cs(cs[1]), .i_write(wr[1]),
        .i_address(addr[1]), .i_dataToWrite(wd[1]), .o_dataRead(rd[1]),
        .o_busy(busy[1]), .o_dataReady(rdy[1]), .o_error(err[1]));

    bram_mem_responder #(.ADDR_WIDTH(12), .LATENCY(1), .INIT_VALUE(8'h00)) u_lat1 (
        .i_clkSys(clk), .i_reset(rst), .i_cs(cs[2]), .i_write(wr[2]),
        .i_address(addr[2]), .i_dataToWrite(wd[2]), .o_dataRead(rd[2]),
        .o_busy(busy[2]), .o_dataReady(rdy[2]), .o_error(err[2]));

    bram_mem_responder #(.ADDR_WIDTH(12), .LATENCY(15), .INIT_VALUE(8'h00)) u_lat15 (
        .i_clkSys(clk), .i_reset(rst), .i_cs(cs[3]), .i_write(wr[3]),
        .i_address(addr[3]), .i_dataToWrite(wd[3]), .o_dataRead(rd[3]),
        .o_busy(busy[3]), .o_dataReady(rdy[3]), .o_error(err[3]));

    // One full access; bc = number of sampled busy cycles, -1 if never idle.
    task automatic do_access(input int k, input logic w, input logic [23:0] a,
                             input logic [7:0] d, output logic [7:0] r,
                             output logic ry, output logic e, output int bc);
        int n;
        n  = 0;
        bc = 0;
        while (busy[k] !== 1'b0 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (busy[k] !== 1'b0) begin
            bc = -1;
        end else begin
            cs[k] = 1'b1;
            @(negedge clk);
            cs[k] = 1'b0; wr[k] = w; addr[k] = a; wd[k] = d;
            @(negedge clk);
            cs[k] = 1'b1;
            while (busy[k] === 1'b1 && bc < 40) begin
                bc++;
                @(negedge clk);
            end
        end
        r  = rd[k];
        ry = rdy[k];
        e  = err[k];
    endtask

    task automatic test_reset();
        int n;
        rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cs[k] = 1'b1; wr[k] = 1'b0; addr[k] = 24'd0; wd[k] = 8'h00;
        end
        @(negedge clk);
        @(negedge clk);
        n_total++; if (busy[0] !== 1'b1) $display("FAIL reset_busy: got %b want 1", busy[0]); else n_pass++;
        n_total++; if (rdy[0] !== 1'b0) $display("FAIL reset_ready: got %b want 0", rdy[0]); else n_pass++;
        n_total++; if (rd[0] !== 8'h00) $display("FAIL reset_data: got %h want 00", rd[0]); else n_pass++;
        n_total++; if (err[0] !== 1'b0) $display("FAIL reset_error: got %b want 0", err[0]); else n_pass++;
        rst = 1'b0;
        n = 0;
        while (busy[1] === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
        n_total++; if (n != 16) $display("FAIL sweep_len: got %0d cycles want 16", n); else n_pass++;
    endtask

    task automatic test_clear_contents();
        logic [7:0] r; logic ry, e; int bc;
        for (int a = 0; a < 16; a++) begin
            do_access(1, 1'b0, 24'(a), 8'h00, r, ry, e, bc);
            n_total++;
            if (r !== 8'h00 || ry !== 1'b1 || bc != 4)
                $display("FAIL clear_read[%0d]: got data=%h rdy=%b busy=%0d want 00/1/4", a, r, ry, bc);
            else n_pass++;
        end
    endtask

    task automatic test_write_read();
        logic [7:0] r; logic ry, e; int bc;
        do_access(0, 1'b1, 24'd1, 8'hAA, r, ry, e, bc);
        n_total++; if (bc != 4) $display("FAIL wr_busy: got %0d want 4", bc); else n_pass++;
        n_total++; if (ry !== 1'b0 || e !== 1'b0) $display("FAIL wr_flags: got rdy=%b err=%b want 0/0", ry, e); else n_pass++;
        do_access(0, 1'b0, 24'd1, 8'h00, r, ry, e, bc);
        n_total++; if (bc != 4) $display("FAIL rd_busy: got %0d want 4", bc); else n_pass++;
        n_total++; if (r !== 8'hAA) $display("FAIL rd_data: got %h want AA", r); else n_pass++;
        n_total++; if (ry !== 1'b1 || e !== 1'b0) $display("FAIL rd_flags: got rdy=%b err=%b want 1/0", ry, e); else n_pass++;
    endtask

    task automatic test_hold_cs();
        int starts; logic prev; int n;
        n = 0;
        while (busy[0] !== 1'b0 && n < 100) begin @(negedge clk); n++; end
        cs[0] = 1'b1; wr[0] = 1'b0; addr[0] = 24'd1;
        @(negedge clk);
        cs[0] = 1'b0;
        starts = 0;
        prev   = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (busy[0] === 1'b1 && prev === 1'b0) starts++;
            prev = busy[0];
        end
        n_total++; if (starts != 1) $display("FAIL hold_cs_accesses: got %0d want 1", starts); else n_pass++;
        cs[0] = 1'b1;
        @(negedge clk);
        cs[0] = 1'b0;
        @(negedge clk);
        n_total++; if (busy[0] !== 1'b1) $display("FAIL rearm_accept: busy=%b want 1", busy[0]); else n_pass++;
        cs[0] = 1'b1;
    endtask

    task automatic test_out_of_range();
        logic [7:0] r; logic ry, e; int bc;
        do_access(0, 1'b1, 24'h001000, 8'h5A, r, ry, e, bc);
        n_total++; if (e !== 1'b1 || ry !== 1'b0) $display("FAIL oor_write: got err=%b rdy=%b want 1/0", e, ry); else n_pass++;
        do_access(0, 1'b0, 24'h000000, 8'h00, r, ry, e, bc);
        n_total++; if (r !== 8'h00 || e !== 1'b0) $display("FAIL oor_alias: got data=%h err=%b want 00/0", r, e); else n_pass++;
        do_access(0, 1'b0, 24'h001000, 8'h00, r, ry, e, bc);
        n_total++;
        if (r !== 8'hFF || e !== 1'b1 || ry !== 1'b1)
            $display("FAIL oor_read: got data=%h err=%b rdy=%b want FF/1/1", r, e, ry);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [7:0] r; logic ry, e; int bc;
        for (int i = 0; i < 8; i++) do_access(0, 1'b1, 24'(32 + i), 8'(i * 37 + 3), r, ry, e, bc);
        for (int i = 0; i < 8; i++) begin
            do_access(0, 1'b0, 24'(32 + i), 8'h00, r, ry, e, bc);
            n_total++;
            if (r !== 8'(i * 37 + 3)) $display("FAIL b2b_read[%0d]: got %h want %h", i, r, 8'(i * 37 + 3));
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid_access();
        logic [7:0] r; logic ry, e; int bc; int n;
        cs[0] = 1'b1;
        @(negedge clk);
        cs[0] = 1'b0; wr[0] = 1'b1; addr[0] = 24'd7; wd[0] = 8'h55;
        @(negedge clk);
        cs[0] = 1'b1;
        @(negedge clk);
        rst   = 1'b1;
        cs[0] = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        n_total++; if (busy[0] !== 1'b1 || rdy[0] !== 1'b0) $display("FAIL midreset_flags: busy=%b rdy=%b want 1/0", busy[0], rdy[0]); else n_pass++;
        n = 0;
        while (busy[0] === 1'b1 && n < 5000) begin n++; @(negedge clk); end
        n_total++; if (n != 4096) $display("FAIL midreset_sweep: got %0d cycles want 4096", n); else n_pass++;
        // i_cs never went high since reset, so nothing may be accepted
        n = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (busy[0] !== 1'b0) n++;
        end
        n_total++; if (n != 0) $display("FAIL unarmed_ignored: busy seen %0d cycles want 0", n); else n_pass++;
        do_access(0, 1'b0, 24'd7, 8'h00, r, ry, e, bc);
        n_total++; if (r !== 8'h00 || ry !== 1'b1) $display("FAIL midreset_read: got %h rdy=%b want 00/1", r, ry); else n_pass++;
    endtask

    task automatic test_latency_loop(input int k, input int lat, input int step);
        logic [7:0] r; logic ry, e; int bc; int bad_busy;
        bad_busy = 0;
        for (int a = 1; a < 4096; a += step) begin
            do_access(k, 1'b1, 24'(a), 8'hAA, r, ry, e, bc);
            if (bc != lat) bad_busy++;
            do_access(k, 1'b0, 24'(a), 8'h00, r, ry, e, bc);
            if (bc != lat) bad_busy++;
            n_total++;
            if (r !== 8'hAA || ry !== 1'b1) $display("FAIL loop_L%0d[%0d]: got %h rdy=%b want AA/1", lat, a, r, ry);
            else n_pass++;
        end
        n_total++; if (bad_busy != 0) $display("FAIL loop_L%0d_busy: %0d accesses wrong length want 0", lat, bad_busy); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_clear_contents();
        test_write_read();
        test_hold_cs();
        test_out_of_range();
        test_back_to_back();
        test_reset_mid_access();
        test_latency_loop(2, 1, 1);
        test_latency_loop(3, 15, 16);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
